// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state codes,
// pointer-width helper and byte-lane selection.
package uart_pkg;

  localparam int MAX_REQ = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_ACCEPT  = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  // Bits needed to index num_req lanes; never less than one.
  function automatic int ptr_width(input int num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [8*MAX_REQ-1:0] lanes,
                                           input logic [2:0]           idx);
    return lanes[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping modulo NUM_REQ, returned both one-hot and as an index.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  // Offsets are scanned from farthest to nearest so the nearest valid lane
  // is the last one written and therefore wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      for (int l = 0; l < NUM_REQ; l++) begin
        if ((int'(ptr_i) + off == l || int'(ptr_i) + off == l + NUM_REQ) && req_i[l]) begin
          grant_o    = '0;
          grant_o[l] = 1'b1;
          idx_o      = PTR_W'(l);
          any_o      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers: round-robin grant,
// valid/ready byte capture, write strobe with accept timeout, optional packet lock.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PACKET_LOCK    = 1,
  parameter int ACCEPT_TIMEOUT = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_write_o,
  input  logic                 tx_busy_i,
  output logic                 retry_o
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam int CNT_W = (ACCEPT_TIMEOUT > 2) ? $clog2(ACCEPT_TIMEOUT) : 1;

  logic [2:0]           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     idx_q, idx_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [7:0]           data_q, data_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 write_q, write_d;
  logic                 retry_q, retry_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [8*MAX_REQ-1:0] lanes;

  assign lanes = (8*MAX_REQ)'(req_data_i);

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // NOTE: every next-state variable gets its hold value before the case, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ready_d = '0;
    write_d = 1'b0;
    retry_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          idx_d   = arb_idx;
          state_d = ST_FETCH;
        end
      end

      // Waiting here with the grant held is how a packet lock stalls on a
      // producer that has not yet presented its next byte.
      ST_FETCH: begin
        if (|(req_valid_i & grant_q)) begin
          ready_d = grant_q;
          data_d  = lane_byte(lanes, 3'(idx_q));
          last_d  = (PACKET_LOCK == 0) || (|(req_last_i & grant_q));
          state_d = ST_WRITE;
        end
      end

      // A late accept of the previous pulse shows up as busy here; skip the
      // re-pulse so the transmitter never sees a write while busy.
      ST_WRITE: begin
        cnt_d = '0;
        if (tx_busy_i) begin
          state_d = ST_DRAIN;
        end else begin
          write_d = 1'b1;
          state_d = ST_ACCEPT;
        end
      end

      ST_ACCEPT: begin
        if (tx_busy_i) begin
          state_d = ST_DRAIN;
        end else if (cnt_q == CNT_W'(ACCEPT_TIMEOUT - 1)) begin
          retry_d = 1'b1;
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        if (!tx_busy_i) state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (!last_q) begin
          state_d = ST_FETCH;
        end else begin
          ptr_d   = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= '0;
      write_q <= 1'b0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      write_q <= write_d;
      retry_q <= retry_d;
    end
  end

  assign req_ready_o = ready_q;
  assign grant_o     = grant_q;
  assign tx_data_o   = data_q;
  assign tx_write_o  = write_q;
  assign retry_o     = retry_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (packet lock on / off), each with queued
// producers and a uart_tx model; byte order is checked against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int TO       = 16;
  localparam int BUSY_LEN = 20;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } item_t;

  typedef struct {
    int         prev_lane;
    logic [3:0] mask;
    logic [3:0] exp_grant;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [N-1:0]   valid    [2];
  logic [N-1:0]   last     [2];
  logic [8*N-1:0] data     [2];
  logic [N-1:0]   ready    [2];
  logic [N-1:0]   grant    [2];
  logic [7:0]     tx_data  [2];
  logic           tx_write [2];
  logic           busy     [2];
  logic           retry    [2];

  item_t      pq [2*N][$];
  item_t      mq [2*N][$];
  logic [7:0] sent_q  [2][$];
  logic [7:0] exp_q   [2][$];
  logic [7:0] wr_data [2][$];
  int         wr_cyc  [2][$];
  int         rt_cyc  [2][$];
  logic       ignore_next [2];
  int         mptr [2];

  uart_tx_arbiter #(.NUM_REQ(N), .PACKET_LOCK(1), .ACCEPT_TIMEOUT(TO)) dut_lock (
    .clock_i(clk), .reset_i(rst),
    .req_valid_i(valid[0]), .req_data_i(data[0]), .req_last_i(last[0]),
    .req_ready_o(ready[0]), .grant_o(grant[0]), .tx_data_o(tx_data[0]),
    .tx_write_o(tx_write[0]), .tx_busy_i(busy[0]), .retry_o(retry[0])
  );

  uart_tx_arbiter #(.NUM_REQ(N), .PACKET_LOCK(0), .ACCEPT_TIMEOUT(TO)) dut_free (
    .clock_i(clk), .reset_i(rst),
    .req_valid_i(valid[1]), .req_data_i(data[1]), .req_last_i(last[1]),
    .req_ready_o(ready[1]), .grant_o(grant[1]), .tx_data_o(tx_data[1]),
    .tx_write_o(tx_write[1]), .tx_busy_i(busy[1]), .retry_o(retry[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh(input int d);
    for (int l = 0; l < N; l++) begin
      if (pq[d*N+l].size() > 0) begin
        valid[d][l]        = 1'b1;
        last[d][l]         = pq[d*N+l][0].last;
        data[d][8*l +: 8]  = pq[d*N+l][0].data;
      end else begin
        valid[d][l]        = 1'b0;
        last[d][l]         = 1'b0;
        data[d][8*l +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic push(input int d, input int lane, input logic [7:0] b, input logic lst);
    item_t it;
    it.data = b;
    it.last = lst;
    pq[d*N+lane].push_back(it);
    mq[d*N+lane].push_back(it);
    refresh(d);
  endtask

  function automatic bit pq_empty(input int d);
    for (int l = 0; l < N; l++)
      if (pq[d*N+l].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: pick the first non-empty producer at/after the pointer; a locked
  // instance drains a whole packet, a free one takes a single byte.
  task automatic predict(input int d);
    bit    lock;
    int    pick;
    int    l;
    item_t it;
    lock = (d == 0);
    forever begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        l = (mptr[d] + k) % N;
        if (pick < 0 && mq[d*N+l].size() > 0) pick = l;
      end
      if (pick < 0) break;
      do begin
        it = mq[d*N+pick].pop_front();
        exp_q[d].push_back(it.data);
      end while (lock && !it.last && mq[d*N+pick].size() > 0);
      mptr[d] = (pick + 1) % N;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle(input int d, input string tag);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 4000) begin
      tick();
      n++;
      done = (sent_q[d].size() >= exp_q[d].size()) && (grant[d] == '0) && pq_empty(d);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_count"}, sent_q[d].size(), exp_q[d].size());
    for (int i = 0; i < exp_q[d].size() && i < sent_q[d].size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(sent_q[d][i]), 32'(exp_q[d][i]));
    sent_q[d].delete();
    exp_q[d].delete();
  endtask

  task automatic check_zero_outputs(input int d, input string tag);
    check({tag, "_ready"},   32'(ready[d]),    32'd0);
    check({tag, "_grant"},   32'(grant[d]),    32'd0);
    check({tag, "_txdata"},  32'(tx_data[d]),  32'd0);
    check({tag, "_txwrite"}, 32'(tx_write[d]), 32'd0);
    check({tag, "_retry"},   32'(retry[d]),    32'd0);
  endtask

  // Producers pop on ready; uart_tx model: busy rises the cycle after a write,
  // stays high BUSY_LEN cycles, and can be told to ignore the next write.
  for (genvar d = 0; d < 2; d++) begin : g_env
    logic pend;
    logic prev_write;
    logic busy_before;
    int   left;
    initial begin
      busy[d]        = 1'b0;
      ignore_next[d] = 1'b0;
      pend           = 1'b0;
      prev_write     = 1'b0;
      left           = 0;
      refresh(d);
      forever begin
        @(negedge clk);
        for (int l = 0; l < N; l++)
          if (ready[d][l] === 1'b1 && pq[d*N+l].size() > 0) void'(pq[d*N+l].pop_front());
        refresh(d);
        if (rst) begin
          busy[d]    = 1'b0;
          pend       = 1'b0;
          prev_write = 1'b0;
          left       = 0;
        end else begin
          busy_before = busy[d];
          if (pend) begin
            busy[d] = 1'b1;
            left    = BUSY_LEN;
            pend    = 1'b0;
          end else if (busy[d]) begin
            left--;
            if (left == 0) busy[d] = 1'b0;
          end
          if (tx_write[d]) begin
            check($sformatf("d%0d_write_while_busy", d), 32'(busy_before), 32'd0);
            check($sformatf("d%0d_write_back_to_back", d), 32'(prev_write), 32'd0);
            wr_data[d].push_back(tx_data[d]);
            wr_cyc[d].push_back(cycle);
            if (ignore_next[d]) ignore_next[d] = 1'b0;
            else begin
              pend = 1'b1;
              sent_q[d].push_back(tx_data[d]);
            end
          end
          if (retry[d]) rt_cyc[d].push_back(cycle);
          prev_write = tx_write[d];
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   n;
    int   npk;
    int   len;
    int   d;

    vecs[0] = '{prev_lane: 2, mask: 4'b1001, exp_grant: 4'b1000};
    vecs[1] = '{prev_lane: 3, mask: 4'b1111, exp_grant: 4'b0001};
    vecs[2] = '{prev_lane: 0, mask: 4'b0101, exp_grant: 4'b0100};
    vecs[3] = '{prev_lane: 1, mask: 4'b0011, exp_grant: 4'b0001};
    vecs[4] = '{prev_lane: 2, mask: 4'b0110, exp_grant: 4'b0010};
    vecs[5] = '{prev_lane: 3, mask: 4'b1000, exp_grant: 4'b1000};

    mptr[0] = 0;
    mptr[1] = 0;
    rst = 1'b1;
    repeat (3) tick();
    check_zero_outputs(0, "rst_lock");
    check_zero_outputs(1, "rst_free");
    rst = 1'b0;
    tick();

    // Single byte: grant +1, ready +2, write +3.
    push(0, 0, 8'h55, 1'b1);
    predict(0);
    tick();
    check("t2_grant", 32'(grant[0]), 32'h1);
    check("t2_ready_early", 32'(ready[0]), 32'h0);
    tick();
    check("t2_ready", 32'(ready[0]), 32'h1);
    check("t2_write_early", 32'(tx_write[0]), 32'h0);
    tick();
    check("t2_write", 32'(tx_write[0]), 32'h1);
    check("t2_txdata", 32'(tx_data[0]), 32'h55);
    n = 0;
    while (busy[0] !== 1'b1 && n < 40) begin tick(); n++; end
    n = 0;
    while (busy[0] !== 1'b0 && n < 40) begin tick(); n++; end
    check("t2_grant_during_drain", 32'(grant[0]), 32'h1);
    n = 0;
    while (grant[0] !== '0 && n < 4) begin tick(); n++; end
    check("t2_grant_released", 32'(grant[0]), 32'h0);
    settle(0, "t2");

    // Reset mid-DRAIN clears outputs asynchronously and the pointer.
    push(0, 1, 8'h77, 1'b1);
    predict(0);
    n = 0;
    while (busy[0] !== 1'b1 && n < 40) begin tick(); n++; end
    check("t1_busy_seen", 32'(busy[0]), 32'd1);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 check_zero_outputs(0, "t1_async");
    repeat (2) tick();
    rst = 1'b0;
    mptr[0] = 0;
    mptr[1] = 0;
    tick();
    check("t1_idle_grant", 32'(grant[0]), 32'h0);
    for (int i = 0; i < 2; i++) begin
      sent_q[i].delete();
      exp_q[i].delete();
    end
    push(0, 3, 8'h30, 1'b1);
    push(0, 0, 8'h01, 1'b1);
    predict(0);
    tick();
    check("t1_ptr_reset_grant", 32'(grant[0]), 32'h1);
    settle(0, "t1");

    // No packet lock: last flags are ignored, strict per-byte rotation.
    push(1, 0, 8'h00, 1'b0);
    push(1, 0, 8'h01, 1'b0);
    push(1, 1, 8'h10, 1'b0);
    push(1, 2, 8'h20, 1'b0);
    push(1, 3, 8'h30, 1'b0);
    predict(1);
    settle(1, "t3");
    check("t3_no_retry", rt_cyc[1].size(), 32'd0);

    // Packet lock: whole req1 packet before req2.
    push(0, 1, 8'hA1, 1'b0);
    push(0, 1, 8'hA2, 1'b0);
    push(0, 1, 8'hA3, 1'b1);
    push(0, 2, 8'hB1, 1'b1);
    predict(0);
    settle(0, "t4");

    // Ignored first write -> retry after the timeout, same data re-pulsed.
    wr_data[0].delete();
    wr_cyc[0].delete();
    rt_cyc[0].delete();
    ignore_next[0] = 1'b1;
    push(0, 3, 8'h3C, 1'b1);
    predict(0);
    settle(0, "t5");
    check("t5_retry_count", rt_cyc[0].size(), 32'd1);
    check("t5_write_count", wr_cyc[0].size(), 32'd2);
    if (rt_cyc[0].size() == 1 && wr_cyc[0].size() == 2) begin
      check("t5_retry_delay", rt_cyc[0][0] - wr_cyc[0][0], TO);
      check("t5_rewrite_delay", wr_cyc[0][1] - rt_cyc[0][0], 32'd1);
      check("t5_data_first", 32'(wr_data[0][0]), 32'h3C);
      check("t5_data_second", 32'(wr_data[0][1]), 32'h3C);
    end

    // Arbitration table: set the pointer with one byte, then offer a mask.
    for (int i = 0; i < 6; i++) begin
      push(0, vecs[i].prev_lane, 8'hE0 | 8'(vecs[i].prev_lane), 1'b1);
      predict(0);
      settle(0, $sformatf("tbl%0d_prev", i));
      for (int l = 0; l < N; l++)
        if (vecs[i].mask[l]) push(0, l, 8'hD0 | 8'(l), 1'b1);
      predict(0);
      tick();
      check($sformatf("tbl%0d_grant", i), 32'(grant[0]), 32'(vecs[i].exp_grant));
      if (i == 0) begin
        n = 0;
        while ((grant[0] === vecs[i].exp_grant || grant[0] === '0) && n < 80) begin tick(); n++; end
        check("tbl0_wrap_grant", 32'(grant[0]), 32'h1);
      end
      settle(0, $sformatf("tbl%0d", i));
    end

    // Random batches on both instances, occasionally ignoring a write.
    for (int r = 0; r < 12; r++) begin
      d = r % 2;
      for (int l = 0; l < N; l++) begin
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) push(d, l, 8'($urandom), (b == len - 1));
        end
      end
      ignore_next[d] = ($urandom_range(0, 3) == 0);
      predict(d);
      settle(d, $sformatf("rnd%0d", r));
      ignore_next[d] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
